// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: 4-digit common-anode hex scanner with tear-free shadow latch and anti-ghost blanking.
// Define SEVEN_SEG_LEADING_ZERO_BLANK_EN to darken leading-zero digits 3..1.
module seven_segment_scanner #(
   parameter int SCAN_DIV     = 10000,
   parameter int BLANK_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] value_in,
   input  logic        blank,
   output logic [3:0]  an_n,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic        frame_start
);
   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLK  = CW'(BLANK_CYCLES);
   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [15:0]   shadow;
   logic          load_pending;
   logic          tick;
   logic          load;
   logic          dark;
   logic [3:0]    nib;
   logic [6:0]    pat;
   assign tick = cnt == LAST;
   assign load = load_pending | (tick & (idx == 2'd3));
   assign nib  = shadow[{idx, 2'b00} +: 4];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
   assign dark = blank | (cnt < BLK) | ((idx != 2'd0) && ((shadow >> {idx, 2'b00}) == 16'h0000));
`else
   assign dark = blank | (cnt < BLK);
`endif
   always_comb begin
      pat = 7'h7F;
      case (nib)
         4'h0: pat = 7'h40;
         4'h1: pat = 7'h79;
         4'h2: pat = 7'h24;
         4'h3: pat = 7'h30;
         4'h4: pat = 7'h19;
         4'h5: pat = 7'h12;
         4'h6: pat = 7'h02;
         4'h7: pat = 7'h78;
         4'h8: pat = 7'h00;
         4'h9: pat = 7'h10;
         4'hA: pat = 7'h08;
         4'hB: pat = 7'h03;
         4'hC: pat = 7'h46;
         4'hD: pat = 7'h21;
         4'hE: pat = 7'h06;
         default: pat = 7'h0E;
      endcase
   end
   // shadow only updates at frame boundaries so a digit never shows a half-updated value
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt          <= '0;
         idx          <= 2'd0;
         shadow       <= 16'h0000;
         load_pending <= 1'b1;
         an_n         <= 4'b1111;
         seg_n        <= 7'h7F;
         dp_n         <= 1'b1;
         frame_start  <= 1'b0;
      end else begin
         cnt          <= tick ? '0 : cnt + 1'b1;
         idx          <= tick ? idx + 2'd1 : idx;
         shadow       <= load ? value_in : shadow;
         load_pending <= 1'b0;
         frame_start  <= load;
         an_n         <= dark ? 4'b1111 : ~(4'b0001 << idx);
         seg_n        <= pat;
         dp_n         <= 1'b1;
      end
   end
endmodule
